// File: rtl/ysyx_22041412_pkg.sv
// Shared types for the AXI read scheduler: FSM states, burst owner and the fixed IF beat size.
package ysyx_22041412_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  // Instruction fetches are always full 64-bit beats.
  localparam logic [2:0] IF_SIZE = 3'd3;

endpackage

// File: rtl/ysyx_22041412_rr_starve.sv
// Grant decision for the IF/MEM read ports: MEM wins by default, but IF is forced through
// once MEM has been granted STARVE_MAX times in a row while IF was waiting.
module ysyx_22041412_rr_starve #(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req_valid,
  input  logic mem_req_valid,
  output logic grant_if,
  output logic grant_mem
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  always_comb begin
    starved   = if_req_valid && (starve_cnt == CNT_MAX);
    grant_mem = idle && mem_req_valid && !starved;
    grant_if  = idle && if_req_valid && !grant_mem;
  end

  // Only MEM grants that actually made IF wait count toward starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_mem && if_req_valid && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22041412_axi_rd_sched.sv
// Single-outstanding AXI read scheduler sharing one AR/R channel between IF and MEM requesters.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; valid, once raised, holds its payload stable until ready.
module ysyx_22041412_axi_rd_sched
  import ysyx_22041412_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int STARVE_MAX     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] if_addr,
  input  logic [7:0]                if_len,
  output logic [AXI_DATA_WIDTH-1:0] if_rdata,
  output logic                      if_rvalid,
  output logic                      if_rlast,
  input  logic                      mem_req_valid,
  output logic                      mem_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]                mem_len,
  input  logic [2:0]                mem_size,
  output logic [AXI_DATA_WIDTH-1:0] mem_rdata,
  output logic                      mem_rvalid,
  output logic                      mem_rlast,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] r_data,
  input  logic                      r_last,
  output logic                      len_err
);

  state_t     state;
  owner_t     owner;
  logic [7:0] beat_cnt;
  logic       grant_if;
  logic       grant_mem;
  logic       beat;
  logic       beat_if;
  logic       beat_mem;

  ysyx_22041412_rr_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .idle          (state == ST_IDLE),
    .if_req_valid  (if_req_valid),
    .mem_req_valid (mem_req_valid),
    .grant_if      (grant_if),
    .grant_mem     (grant_mem)
  );

  // r_ready is registered high only in DATA, so it doubles as the beat qualifier.
  always_comb begin
    beat     = r_ready && r_valid;
    beat_if  = beat && (owner == OWN_IF);
    beat_mem = beat && (owner == OWN_MEM);

    if_rvalid  = beat_if;
    if_rlast   = beat_if && r_last;
    if_rdata   = beat_if ? r_data : '0;
    mem_rvalid = beat_mem;
    mem_rlast  = beat_mem && r_last;
    mem_rdata  = beat_mem ? r_data : '0;

    if_req_ready  = ar_valid && ar_ready && (owner == OWN_IF);
    mem_req_ready = ar_valid && ar_ready && (owner == OWN_MEM);

    // ar_len holds the granted length for the whole burst.
    len_err = beat && (r_last ? (beat_cnt != ar_len) : (beat_cnt == ar_len));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      beat_cnt <= '0;
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_mem) begin
            owner    <= OWN_MEM;
            ar_addr  <= mem_addr;
            ar_len   <= mem_len;
            ar_size  <= mem_size;
            ar_valid <= 1'b1;
            state    <= ST_ADDR;
          end else if (grant_if) begin
            owner    <= OWN_IF;
            ar_addr  <= if_addr;
            ar_len   <= if_len;
            ar_size  <= IF_SIZE;
            ar_valid <= 1'b1;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_valid) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (r_last) begin
              r_ready <= 1'b0;
              owner   <= OWN_NONE;
              state   <= ST_IDLE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          owner    <= OWN_NONE;
          ar_valid <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_axi_rd_sched.sv
// Bench for the AXI read scheduler: arbitration/starvation sequences, a burst vector table,
// and reset-in-flight; read beats are checked against an expected queue.
module tb_ysyx_22041412_axi_rd_sched;
  import ysyx_22041412_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int EW = DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_addr;
  logic [7:0]    if_len;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid, if_rlast;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_len;
  logic [2:0]    mem_size;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid, mem_rlast;
  logic          ar_valid, ar_ready;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic          r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          len_err;

  int n_cmp  = 0;
  int n_miss = 0;

  // Entry layout: {is_if, last, len_err, data}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  typedef struct {
    bit         is_if;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [2:0]  exp_size;
    int          nbeats;
    int          ar_delay;
    int          exp_nerr;
  } vec_t;

  vec_t vecs[7];

  ysyx_22041412_axi_rd_sched #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .STARVE_MAX     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_len        (if_len),
    .if_rdata      (if_rdata),
    .if_rvalid     (if_rvalid),
    .if_rlast      (if_rlast),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_len       (mem_len),
    .mem_size      (mem_size),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rlast     (mem_rlast),
    .ar_valid      (ar_valid),
    .ar_ready      (ar_ready),
    .ar_addr       (ar_addr),
    .ar_len        (ar_len),
    .ar_size       (ar_size),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_data        (r_data),
    .r_last        (r_last),
    .len_err       (len_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid || mem_rvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_miss++;
          $display("FAIL unexpected_beat: if_rvalid=%0b mem_rvalid=%0b with empty queue", if_rvalid, mem_rvalid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_if_rvalid", {63'd0, if_rvalid}, {63'd0, mon_e[EW-1]});
          chk("beat_mem_rvalid", {63'd0, mem_rvalid}, {63'd0, !mon_e[EW-1]});
          chk("beat_rdata", mon_e[EW-1] ? if_rdata : mem_rdata, mon_e[DW-1:0]);
          chk("beat_nonowner_rdata", mon_e[EW-1] ? mem_rdata : if_rdata, 64'd0);
          chk("beat_rlast", {63'd0, if_rlast | mem_rlast}, {63'd0, mon_e[EW-2]});
          chk("beat_len_err", {63'd0, len_err}, {63'd0, mon_e[EW-3]});
        end
      end else begin
        chk("len_err_no_beat", {63'd0, len_err}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at the start of the first ADDR cycle; leaves at the start of the first DATA cycle.
  task automatic addr_phase(input bit is_if, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int delay);
    @(negedge clk);
    chk("ar_valid", {63'd0, ar_valid}, 64'd1);
    chk("ar_addr", {32'd0, ar_addr}, {32'd0, addr});
    chk("ar_len", {56'd0, ar_len}, {56'd0, len});
    chk("ar_size", {61'd0, ar_size}, {61'd0, size});
    for (int d = 0; d < delay; d++) begin
      step();
      @(negedge clk);
      chk("ar_hold_valid", {63'd0, ar_valid}, 64'd1);
      chk("ar_hold_addr", {32'd0, ar_addr}, {32'd0, addr});
      chk("ar_hold_len", {56'd0, ar_len}, {56'd0, len});
      chk("req_ready_wait", {62'd0, if_req_ready, mem_req_ready}, 64'd0);
    end
    step();
    ar_ready = 1'b1;
    @(negedge clk);
    chk("if_req_ready_hs", {63'd0, if_req_ready}, {63'd0, is_if});
    chk("mem_req_ready_hs", {63'd0, mem_req_ready}, {63'd0, !is_if});
    step();
    ar_ready = 1'b0;
    if (is_if) if_req_valid = 1'b0;
    else mem_req_valid = 1'b0;
  endtask

  // Entered at the start of the first DATA cycle; leaves inside the following IDLE cycle.
  task automatic data_phase(input bit is_if, input logic [7:0] len, input int nbeats, input int exp_nerr);
    int nerr;
    logic lerr;
    nerr = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        r_valid = 1'b0;
        r_data  = {$urandom, $urandom};
        @(negedge clk);
        nerr += int'(len_err);
        step();
      end
      r_valid = 1'b1;
      r_data  = {$urandom, $urandom};
      r_last  = (i == nbeats - 1);
      lerr    = r_last ? (i != int'(len)) : (i == int'(len));
      exp_q.push_back({is_if, r_last, lerr, r_data});
      @(negedge clk);
      chk("r_ready_data", {63'd0, r_ready}, 64'd1);
      if (i == 0) chk("req_ready_once", {62'd0, if_req_ready, mem_req_ready}, 64'd0);
      nerr += int'(len_err);
      step();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    #1;
    chk("len_err_pulses", nerr, exp_nerr);
    chk("idle_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("idle_r_ready", {63'd0, r_ready}, 64'd0);
    chk("idle_state", {62'd0, dut.state}, {62'd0, ST_IDLE});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{1'b1, 32'h8000_0000, 8'd3, 3'd0, 3'd3, 4, 5, 0};
    vecs[1] = '{1'b0, 32'h0000_1000, 8'd1, 3'd2, 3'd2, 1, 0, 1};
    vecs[2] = '{1'b0, 32'h0000_2008, 8'd0, 3'd3, 3'd3, 1, 1, 0};
    vecs[3] = '{1'b0, 32'h0000_3004, 8'd1, 3'd2, 3'd2, 3, 2, 2};
    vecs[4] = '{1'b1, 32'h8000_0040, 8'd7, 3'd5, 3'd3, 8, 0, 0};
    vecs[5] = '{1'b0, 32'h0000_5000, 8'd4, 3'd1, 3'd1, 5, 3, 0};
    vecs[6] = '{1'b1, 32'h8000_0080, 8'd2, 3'd0, 3'd3, 2, 1, 1};

    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0; if_len = '0;
    mem_req_valid = 1'b0; mem_addr = '0; mem_len = '0; mem_size = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
    chk("rst_outputs", {58'd0, if_req_ready, mem_req_ready, if_rvalid, mem_rvalid, len_err, ar_len != 0}, 64'd0);
    chk("rst_state", {62'd0, dut.state}, {62'd0, ST_IDLE});
    chk("rst_starve", {61'd0, dut.u_arb.starve_cnt}, 64'd0);
    step();
    rst = 1'b0;

    // Simultaneous requests: MEM first, then IF.
    if_req_valid = 1'b1; if_addr = 32'h8000_0100; if_len = 8'd1;
    mem_req_valid = 1'b1; mem_addr = 32'h0000_2000; mem_len = 8'd2; mem_size = 3'd2;
    step();
    addr_phase(1'b0, 32'h0000_2000, 8'd2, 3'd2, 0);
    chk("both_starve_after_mem", {61'd0, dut.u_arb.starve_cnt}, 64'd1);
    data_phase(1'b0, 8'd2, 3, 0);
    step();
    addr_phase(1'b1, 32'h8000_0100, 8'd1, 3'd3, 0);
    chk("both_starve_after_if", {61'd0, dut.u_arb.starve_cnt}, 64'd0);
    data_phase(1'b1, 8'd1, 2, 0);

    // Starvation: IF waits through four MEM bursts, then wins.
    if_req_valid = 1'b1; if_addr = 32'h8000_0200; if_len = 8'd0;
    mem_len = 8'd0; mem_size = 3'd3;
    for (int k = 0; k < 4; k++) begin
      mem_req_valid = 1'b1;
      mem_addr = 32'h0000_0100 * k;
      step();
      addr_phase(1'b0, 32'h0000_0100 * k, 8'd0, 3'd3, 0);
      mem_req_valid = 1'b1;
      chk("starve_cnt_mem", {61'd0, dut.u_arb.starve_cnt}, k + 1);
      data_phase(1'b0, 8'd0, 1, 0);
    end
    step();
    addr_phase(1'b1, 32'h8000_0200, 8'd0, 3'd3, 0);
    mem_req_valid = 1'b0;
    chk("starve_cnt_if", {61'd0, dut.u_arb.starve_cnt}, 64'd0);
    data_phase(1'b1, 8'd0, 1, 0);

    // Burst vector table.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].is_if) begin
        if_req_valid = 1'b1; if_addr = vecs[v].addr; if_len = vecs[v].len;
      end else begin
        mem_req_valid = 1'b1; mem_addr = vecs[v].addr; mem_len = vecs[v].len; mem_size = vecs[v].size;
      end
      step();
      addr_phase(vecs[v].is_if, vecs[v].addr, vecs[v].len, vecs[v].exp_size, vecs[v].ar_delay);
      data_phase(vecs[v].is_if, vecs[v].len, vecs[v].nbeats, vecs[v].exp_nerr);
    end

    // A request withdrawn before the IDLE edge must not be granted.
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    step();
    chk("dropped_no_ar", {63'd0, ar_valid}, 64'd0);
    chk("dropped_state", {62'd0, dut.state}, {62'd0, ST_IDLE});

    // Reset in the middle of an 8-beat burst.
    mem_req_valid = 1'b1; mem_addr = 32'h0000_4000; mem_len = 8'd7; mem_size = 3'd3;
    step();
    addr_phase(1'b0, 32'h0000_4000, 8'd7, 3'd3, 0);
    for (int i = 0; i < 2; i++) begin
      r_valid = 1'b1; r_data = {$urandom, $urandom}; r_last = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 1'b0, r_data});
      step();
    end
    r_valid = 1'b1; r_data = {$urandom, $urandom};
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_rvalid", {63'd0, mem_rvalid}, 64'd0);
    chk("rst_mid_mem_rdata", mem_rdata, 64'd0);
    chk("rst_mid_r_ready", {63'd0, r_ready}, 64'd0);
    chk("rst_mid_misc", {60'd0, ar_valid, len_err, mem_rlast, mem_req_ready}, 64'd0);
    step();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      r_data = {$urandom, $urandom};
      r_last = (j == 2);
      @(negedge clk);
      chk("post_rst_r_ready", {63'd0, r_ready}, 64'd0);
      chk("post_rst_rvalid", {62'd0, if_rvalid, mem_rvalid}, 64'd0);
      step();
    end
    chk("post_rst_starve", {61'd0, dut.u_arb.starve_cnt}, 64'd0);
    chk("post_rst_state", {62'd0, dut.state}, {62'd0, ST_IDLE});
    r_valid = 1'b0; r_last = 1'b0;
    mem_req_valid = 1'b1; mem_addr = 32'h0000_6000; mem_len = 8'd1; mem_size = 3'd2;
    step();
    addr_phase(1'b0, 32'h0000_6000, 8'd1, 3'd2, 0);
    data_phase(1'b0, 8'd1, 2, 0);

    step();
    chk("exp_q_drained", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #500000;
    n_miss++;
    $display("FAIL watchdog: run did not complete, %0d expected beats outstanding", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_22041412_axi_rd_sched.md
YSYX_22041412_AXI_RD_SCHED -- requirements
Module: ysyx_22041412_axi_rd_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): AXI_DATA_WIDTH, 64, read data width; AXI_ADDR_WIDTH, 32, address width; STARVE_MAX, 4, consecutive MEM grants tolerated while IF waits.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- if_req_valid, in, 1, IF read request.
- if_req_ready, out, 1, IF request accepted (AR handshake).
- if_addr, in, AXI_ADDR_WIDTH, IF address.
- if_len, in, 8, IF burst length minus 1.
- if_rdata, out, AXI_DATA_WIDTH, IF read beat.
- if_rvalid, out, 1, IF beat valid.
- if_rlast, out, 1, IF final beat.
- mem_req_valid, in, 1, MEM read request.
- mem_req_ready, out, 1, MEM request accepted.
- mem_addr, in, AXI_ADDR_WIDTH, MEM address.
- mem_len, in, 8, MEM burst length minus 1.
- mem_size, in, 3, MEM beat size (log2 bytes).
- mem_rdata, out, AXI_DATA_WIDTH, MEM read beat.
- mem_rvalid, out, 1, MEM beat valid.
- mem_rlast, out, 1, MEM final beat.
- ar_valid, out, 1, AXI AR valid.
- ar_ready, in, 1, AXI AR ready.
- ar_addr, out, AXI_ADDR_WIDTH, AR address.
- ar_len, out, 8, AR length.
- ar_size, out, 3, AR size.
- r_valid, in, 1, AXI R valid.
- r_ready, out, 1, AXI R ready.
- r_data, in, AXI_DATA_WIDTH, R data.
- r_last, in, 1, R last.
- len_err, out, 1, one-cycle pulse on a burst beat-count mismatch.

Function
REQ-003 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, holding exactly one outstanding read.
REQ-004 In IDLE, grant SHALL go to MEM when mem_req_valid, unless if_req_valid and starve_cnt==STARVE_MAX, in which case IF is granted; otherwise IF when if_req_valid; otherwise stay IDLE.
REQ-005 On grant SHALL register owner, addr, len and size (size=3 for IF), and enter ADDR next cycle.
REQ-006 starve_cnt SHALL increment (saturating at STARVE_MAX) when MEM is granted while if_req_valid=1, and SHALL clear when IF is granted.
REQ-007 In ADDR: ar_valid=1 with registered fields held stable; on ar_valid&ar_ready, pulse the owner's req_ready for one cycle and enter DATA.
REQ-008 Requesters SHALL hold valid/addr/len stable until their req_ready; the block does not re-sample them after the grant.
REQ-009 In DATA: r_ready=1; each r_valid beat SHALL be forwarded combinationally to the owner only (rdata/rvalid/rlast); the non-owner sees rvalid=0, rdata=0.
REQ-010 beat_cnt (8-bit) SHALL clear on entry to DATA and increment per accepted beat.
REQ-011 On the r_last beat SHALL return to IDLE; len_err SHALL pulse if beat_cnt!=registered len at that beat.
REQ-012 A beat with beat_cnt==len and r_last=0 SHALL pulse len_err and continue accepting beats until r_last.
REQ-013 Minimum latency: request seen in IDLE cycle N -> ar_valid in cycle N+1; after r_last, next grant no earlier than the following IDLE cycle.
REQ-014 Simultaneous IF and MEM requests with starve_cnt<STARVE_MAX SHALL grant MEM; requests dropped in IDLE SHALL cause no grant.
REQ-015 Outside ADDR, ar_valid=0; outside DATA, r_ready=0 and all rvalid/rlast=0.

Reset
REQ-016 rst SHALL asynchronously force IDLE, starve_cnt=0, beat_cnt=0, owner=none, and all outputs to 0, including mid-burst; in-flight beats after release SHALL be ignored (r_ready=0).

Structure
REQ-017 State encodings, the owner enum (NONE/IF/MEM) and IF_SIZE=3 SHALL live in the shared ysyx_22041412 package.
REQ-018 A single sub-module, ysyx_22041412_rr_starve (grant decision plus starve counter), is natural; everything else stays flat.

Verification
REQ-019 Both request in IDLE, starve_cnt=0 -> MEM AR first (ar_size=mem_size), then IF; starve_cnt=1 after the MEM grant.
REQ-020 IF held valid, MEM re-requests continuously, STARVE_MAX=4 -> four MEM bursts, then IF granted on the fifth; starve_cnt returns to 0.
REQ-021 IF len=3, ar_ready delayed 5 cycles -> ar fields stable, if_req_ready pulses once; 4 beats with rlast on the 4th; len_err=0.
REQ-022 MEM len=1, slave gives r_last on beat 0 -> len_err pulses with that beat; FSM back in IDLE next cycle.
REQ-023 rst asserted in DATA after 2 of 8 beats -> outputs 0 immediately; r_ready=0 after release until a new grant.
